wide_alu_queued: RTL

Parametrised successor of the PULP-training wide ALU: a command-queued, handshaked wide-integer ALU with a programmable de-acceleration delay. Commands (opcode plus operands) enter through a valid/ready port into a CMD_DEPTH-entry FIFO. A single execution engine drains the FIFO and presents each 2*ALU_WIDTH-bit result on a valid/ready result port. The block sits behind the same register-file/bus adapter as the earlier ALU and replaces it where back-to-back operations are needed.

---
 rtl/wide_alu_pkg.sv | 28 ++
 rtl/wide_alu_cmd_fifo.sv | 54 +++++
 rtl/wide_alu_queued.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/wide_alu_pkg.sv
// Shared types for the queued wide ALU: opcodes, engine status and the queued command word.
package wide_alu_pkg;

   // Upper bound on operand width carried by a queued command.
   localparam int ALU_WIDTH_MAX = 256;

   typedef enum logic [2:0] {
      ADD = 3'd0,
      SUB = 3'd1,
      MUL = 3'd2,
      XOR = 3'd3,
      AND = 3'd4,
      OR  = 3'd5
   } optype_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } status_e;

   typedef struct packed {
      optype_e                  op;
      logic [ALU_WIDTH_MAX-1:0] a;
      logic [ALU_WIDTH_MAX-1:0] b;
   } cmd_t;

endpackage

// File: rtl/wide_alu_cmd_fifo.sv
// Command FIFO for the wide ALU: DEPTH entries (power of two), no pass-through when full.
module wide_alu_cmd_fifo
   import wide_alu_pkg::*;
#(
   parameter type T     = cmd_t,
   parameter int  DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  T                         wdata,
   input  logic                     pop,
   output T                         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int AW = $clog2(DEPTH);

   T               mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    count;
   logic           do_push, do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   // A full FIFO refuses the push even when the same cycle pops.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];
   assign fill    = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/wide_alu_queued.sv
// Command-queued wide ALU with programmable de-acceleration delay.
// Define WIDE_ALU_MUL_EN to build the multiplier; otherwise MUL reports an error.
module wide_alu_queued
   import wide_alu_pkg::*;
#(
   parameter int ALU_WIDTH             = 256,
   parameter int CMD_DEPTH             = 4,
   parameter int DEACCEL_COUNTER_WIDTH = 8
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               cmd_valid_i,
   output logic                               cmd_ready_o,
   input  optype_e                            cmd_op_i,
   input  logic [ALU_WIDTH-1:0]               cmd_a_i,
   input  logic [ALU_WIDTH-1:0]               cmd_b_i,
   output logic                               res_valid_o,
   input  logic                               res_ready_i,
   output logic [2*ALU_WIDTH-1:0]             res_data_o,
   output logic                               res_err_o,
   input  logic                               deaccel_factor_we_i,
   input  logic [DEACCEL_COUNTER_WIDTH-1:0]   deaccel_factor_i,
   output logic [DEACCEL_COUNTER_WIDTH-1:0]   deaccel_factor_o,
   input  logic                               clear_err_i,
   output logic                               err_write_o,
   output logic [$clog2(CMD_DEPTH):0]         fill_o,
   output status_e                            status_o
);

   localparam int RW = 2*ALU_WIDTH;
   localparam int CW = DEACCEL_COUNTER_WIDTH;

   cmd_t          cmd_in, head, cur_q;
   logic          fifo_full, fifo_empty, pop, finish;
   status_e       state_q, state_d;
   logic [CW-1:0] cntr_q, factor_q, d_eff;
   logic [RW-1:0] a_ext, b_ext, res_q, res_d;
   logic          err_q, err_d, err_write_q;

   // Operands are queued at ALU_WIDTH_MAX and trimmed back on execution.
   assign cmd_in.op = cmd_op_i;
   assign cmd_in.a  = ALU_WIDTH_MAX'(cmd_a_i);
   assign cmd_in.b  = ALU_WIDTH_MAX'(cmd_b_i);

   wide_alu_cmd_fifo #(.T(cmd_t), .DEPTH(CMD_DEPTH)) u_fifo (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .push  (cmd_valid_i),
      .wdata (cmd_in),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .fill  (fill_o)
   );

   // A factor of zero is treated as one.
   assign d_eff = (factor_q == '0) ? CW'(1) : factor_q;

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE: if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = BUSY;
         end
         BUSY: if (cntr_q >= d_eff) begin
            finish  = 1'b1;
            state_d = DONE;
         end
         DONE: if (res_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign a_ext = RW'(cur_q.a[ALU_WIDTH-1:0]);
   assign b_ext = RW'(cur_q.b[ALU_WIDTH-1:0]);

   always_comb begin
      res_d = '0;
      err_d = 1'b0;
      case (cur_q.op)
         ADD:     res_d = a_ext + b_ext;
         SUB:     res_d = a_ext - b_ext;
`ifdef WIDE_ALU_MUL_EN
         MUL:     res_d = a_ext * b_ext;
`endif
         XOR:     res_d = a_ext ^ b_ext;
         AND:     res_d = a_ext & b_ext;
         OR:      res_d = a_ext | b_ext;
         default: err_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cntr_q  <= '0;
         cur_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (pop) begin
            cur_q  <= head;
            cntr_q <= CW'(1);
         end else if (finish) begin
            res_q <= res_d;
            err_q <= err_d;
         end else if (state_q == BUSY) begin
            cntr_q <= cntr_q + CW'(1);
         end else if (state_q == DONE && res_ready_i) begin
            cntr_q <= '0;
         end
      end
   end

   // Factor writes only land while IDLE so an in-flight delay is never disturbed.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         factor_q    <= CW'(1);
         err_write_q <= 1'b0;
      end else begin
         if (deaccel_factor_we_i && state_q == IDLE) factor_q <= deaccel_factor_i;
         if (deaccel_factor_we_i && state_q != IDLE) err_write_q <= 1'b1;
         else if (clear_err_i)                       err_write_q <= 1'b0;
      end
   end

   assign cmd_ready_o      = !fifo_full;
   assign res_valid_o      = (state_q == DONE);
   assign res_data_o       = res_q;
   assign res_err_o        = err_q;
   assign deaccel_factor_o = factor_q;
   assign err_write_o      = err_write_q;
   assign status_o         = state_q;

endmodule
